// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request / write-beat / read-beat bundle between an
//                accelerator-side initiator (master) and mem_responder (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_responder_if #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64
);
    // Request channel: one-cycle strobe per request
    logic                     mem_req_valid;
    logic                     mem_req_opcode;
    logic [MEM_LEN_BITS-1:0]  mem_req_len;
    logic [MEM_ADDR_BITS-1:0] mem_req_addr;

    // Write-beat channel: no backpressure
    logic                     mem_wr_valid;
    logic [MEM_DATA_BITS-1:0] mem_wr_bits;

    // Read-beat channel: valid/ready
    logic                     mem_rd_valid;
    logic [MEM_DATA_BITS-1:0] mem_rd_bits;
    logic                     mem_rd_ready;

    modport master (
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits,
        input  mem_rd_valid, mem_rd_bits,
        output mem_rd_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits,
        output mem_rd_valid, mem_rd_bits,
        input  mem_rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Simulation memory behind the accelerator memory port.
//                Single-outstanding burst reads/writes, configurable read
//                latency, backdoor preload/inspect port, sticky error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 32,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH_BITS    = 10,
    parameter int RD_LATENCY    = 2
) (
    input  wire                      clock,
    input  wire                      reset,      // asynchronous, active-low
    mem_responder_if.slave           mem,
    input  wire                      bd_we,
    input  wire [DEPTH_BITS-1:0]     bd_addr,
    input  wire [MEM_DATA_BITS-1:0]  bd_wdata,
    output logic [MEM_DATA_BITS-1:0] bd_rdata,
    output logic                     busy,
    output logic                     err,
    input  wire                      err_clr
);

    localparam int OFFSET_BITS = $clog2(MEM_DATA_BITS / 8);
    localparam int WORDS       = 1 << DEPTH_BITS;
    localparam int WAIT_BITS   = (RD_LATENCY < 1) ? 1 : $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_BITS-1:0]   ptr_q, ptr_d;
    logic [MEM_LEN_BITS-1:0] remain_q, remain_d;
    logic [WAIT_BITS-1:0]    wait_q, wait_d;
    logic                    err_q, err_d;

    logic                    err_set;
    logic                    wr_en;
    logic [DEPTH_BITS-1:0]   req_idx;

    logic [MEM_DATA_BITS-1:0] mem_array [WORDS];

    // Byte-offset bits and bits above the array depth do not select a word
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem.mem_req_addr;

    assign req_idx = mem.mem_req_addr[OFFSET_BITS +: DEPTH_BITS];

    // Next-state, pointer/counter updates and error detection
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        wait_d   = wait_q;
        wr_en    = 1'b0;
        err_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem.mem_req_valid) begin
                    ptr_d    = req_idx;
                    remain_d = mem.mem_req_len;
                    if (mem.mem_req_opcode) begin
                        state_d = WR_DATA;
                    end else if (RD_LATENCY > 0) begin
                        state_d = RD_WAIT;
                        wait_d  = WAIT_BITS'(RD_LATENCY);
                    end else begin
                        state_d = RD_DATA;
                    end
                end
            end
            RD_WAIT: begin
                // Leaving at a count of 1 puts the first beat RD_LATENCY+1
                // cycles after the request cycle.
                if (wait_q <= WAIT_BITS'(1)) begin
                    state_d = RD_DATA;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q - WAIT_BITS'(1);
                end
            end
            RD_DATA: begin
                if (mem.mem_rd_ready) begin
                    ptr_d = ptr_q + DEPTH_BITS'(1);
                    if (remain_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remain_d = remain_q - MEM_LEN_BITS'(1);
                    end
                end
            end
            WR_DATA: begin
                if (mem.mem_wr_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + DEPTH_BITS'(1);
                    if (remain_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        remain_d = remain_q - MEM_LEN_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request outside IDLE is dropped; the burst in flight carries on
        if (mem.mem_req_valid && (state_q != IDLE)) begin
            err_set = 1'b1;
        end
        // A write beat outside WR_DATA is ignored
        if (mem.mem_wr_valid && (state_q != WR_DATA)) begin
            err_set = 1'b1;
        end

        // Setting beats clearing when both happen in one cycle
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control state register, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            remain_q <= '0;
            wait_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
        end
    end

    // Word array: backdoor write first so a same-word burst beat overrides it
    always_ff @(posedge clock) begin
        if (bd_we) begin
            mem_array[bd_addr] <= bd_wdata;
        end
        if (wr_en) begin
            mem_array[ptr_q] <= mem.mem_wr_bits;
        end
    end

    // Read data follows the array directly so backdoor edits show up at once
    always_comb begin
        mem.mem_rd_valid = (state_q == RD_DATA);
        mem.mem_rd_bits  = mem_array[ptr_q];
        bd_rdata         = mem_array[bd_addr];
        busy             = (state_q != IDLE);
        err              = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Directed self-checking bench for mem_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    localparam int LEN_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 10;

    logic              clock;
    logic              reset;
    logic              bd_we;
    logic [DEPTH-1:0]  bd_addr;
    logic [DATA_W-1:0] bd_wdata;
    logic [DATA_W-1:0] bd_rdata;
    logic              busy;
    logic              err;
    logic              err_clr;

    int checks;
    int failures;

    mem_responder_if #(
        .MEM_LEN_BITS (LEN_W),
        .MEM_ADDR_BITS(ADDR_W),
        .MEM_DATA_BITS(DATA_W)
    ) mif ();

    mem_responder #(
        .MEM_LEN_BITS (LEN_W),
        .MEM_ADDR_BITS(ADDR_W),
        .MEM_DATA_BITS(DATA_W),
        .DEPTH_BITS   (DEPTH),
        .RD_LATENCY   (2)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .mem     (mif.slave),
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input int idx, input logic [63:0] exp);
        bd_addr = DEPTH'(idx);
        #1;
        check(tag, bd_rdata, exp);
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        bd_we    = 1'b1;
        bd_addr  = DEPTH'(idx);
        bd_wdata = val;
        tick();
        bd_we    = 1'b0;
    endtask

    // Drives a one-cycle request; returns in the cycle after acceptance
    task automatic request(input logic op, input int len, input logic [31:0] addr);
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_opcode = op;
        mif.mem_req_len    = LEN_W'(len);
        mif.mem_req_addr   = addr;
        tick();
        mif.mem_req_valid  = 1'b0;
    endtask

    logic [63:0] got [4];
    logic [63:0] held;
    logic        stalled;
    int          nbeats;
    int          vk;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_wdata = '0;
        err_clr  = 1'b0;
        mif.mem_req_valid  = 1'b0;
        mif.mem_req_opcode = 1'b0;
        mif.mem_req_len    = '0;
        mif.mem_req_addr   = '0;
        mif.mem_wr_valid   = 1'b0;
        mif.mem_wr_bits    = '0;
        mif.mem_rd_ready   = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_rd_valid", 64'(mif.mem_rd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        reset = 1'b1;
        tick();

        // Preload words 0..3
        preload(0, 64'h11);
        preload(1, 64'h22);
        preload(2, 64'h33);
        preload(3, 64'h44);
        check_word("preload_w2", 2, 64'h33);

        // Burst read, ready held high: first beat 3 cycles after request
        request(1'b0, 3, 32'h0);
        check("rd1_lat_c1", 64'(mif.mem_rd_valid), 64'd0);
        check("rd1_busy_c1", 64'(busy), 64'd1);
        tick();
        check("rd1_lat_c2", 64'(mif.mem_rd_valid), 64'd0);
        tick();
        check("rd1_valid_c3", 64'(mif.mem_rd_valid), 64'd1);
        check("rd1_beat0", mif.mem_rd_bits, 64'h11);
        tick();
        check("rd1_beat1", mif.mem_rd_bits, 64'h22);
        tick();
        check("rd1_beat2", mif.mem_rd_bits, 64'h33);
        tick();
        check("rd1_beat3", mif.mem_rd_bits, 64'h44);
        check("rd1_valid_b3", 64'(mif.mem_rd_valid), 64'd1);
        tick();
        check("rd1_done_valid", 64'(mif.mem_rd_valid), 64'd0);
        check("rd1_done_busy", 64'(busy), 64'd0);

        // Same read with ready pattern 1,0,0,1,0,0,... over valid cycles
        request(1'b0, 3, 32'h0);
        nbeats  = 0;
        vk      = 0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 40 && nbeats < 4; cyc++) begin
            if (mif.mem_rd_valid === 1'b1) begin
                if (stalled) check("rd2_hold", mif.mem_rd_bits, held);
                mif.mem_rd_ready = (vk % 3 == 0);
                if (mif.mem_rd_ready) begin
                    got[nbeats] = mif.mem_rd_bits;
                    nbeats++;
                    stalled = 1'b0;
                end else begin
                    held    = mif.mem_rd_bits;
                    stalled = 1'b1;
                end
                vk++;
            end else begin
                mif.mem_rd_ready = 1'b0;
            end
            tick();
        end
        mif.mem_rd_ready = 1'b1;
        check("rd2_nbeats", 64'(nbeats), 64'd4);
        check("rd2_beat0", got[0], 64'h11);
        check("rd2_beat1", got[1], 64'h22);
        check("rd2_beat2", got[2], 64'h33);
        check("rd2_beat3", got[3], 64'h44);
        check("rd2_no_extra", 64'(mif.mem_rd_valid), 64'd0);
        check("rd2_idle", 64'(busy), 64'd0);

        // Burst write to 0x40 (index 8), two idle cycles between beats
        request(1'b1, 1, 32'h40);
        mif.mem_wr_valid = 1'b1;
        mif.mem_wr_bits  = 64'hAAAA;
        tick();
        mif.mem_wr_valid = 1'b0;
        check("wr_rdv_a", 64'(mif.mem_rd_valid), 64'd0);
        tick();
        check("wr_stall_busy", 64'(busy), 64'd1);
        tick();
        mif.mem_wr_valid = 1'b1;
        mif.mem_wr_bits  = 64'hBBBB;
        tick();
        mif.mem_wr_valid = 1'b0;
        check("wr_rdv_b", 64'(mif.mem_rd_valid), 64'd0);
        check("wr_done_busy", 64'(busy), 64'd0);
        check("wr_err", 64'(err), 64'd0);
        check_word("wr_w8", 8, 64'hAAAA);
        check_word("wr_w9", 9, 64'hBBBB);

        // Wrap: index 1023 then index 0
        request(1'b1, 1, 32'h1FF8);
        mif.mem_wr_valid = 1'b1;
        mif.mem_wr_bits  = 64'hC1;
        tick();
        mif.mem_wr_bits  = 64'hC2;
        tick();
        mif.mem_wr_valid = 1'b0;
        check_word("wrap_w1023", 1023, 64'hC1);
        check_word("wrap_w0", 0, 64'hC2);
        check("wrap_busy", 64'(busy), 64'd0);

        // Second request mid-read: error, original burst unchanged
        request(1'b0, 1, 32'h8);
        mif.mem_req_valid  = 1'b1;
        mif.mem_req_opcode = 1'b1;
        mif.mem_req_len    = '0;
        mif.mem_req_addr   = 32'h40;
        tick();
        mif.mem_req_valid  = 1'b0;
        check("err_midreq", 64'(err), 64'd1);
        check("midreq_wait", 64'(mif.mem_rd_valid), 64'd0);
        tick();
        check("midreq_beat0", mif.mem_rd_bits, 64'h22);
        tick();
        check("midreq_beat1", mif.mem_rd_bits, 64'h33);
        tick();
        check("midreq_done", 64'(busy), 64'd0);

        // err_clr clears
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", 64'(err), 64'd0);

        // Stray write beat in IDLE: error, array untouched
        mif.mem_wr_valid = 1'b1;
        mif.mem_wr_bits  = 64'hDEAD;
        tick();
        mif.mem_wr_valid = 1'b0;
        check("err_stray_wr", 64'(err), 64'd1);
        check_word("stray_w3", 3, 64'h44);
        check_word("stray_w1", 1, 64'h22);

        // Set wins over clear in the same cycle
        err_clr          = 1'b1;
        mif.mem_wr_valid = 1'b1;
        tick();
        mif.mem_wr_valid = 1'b0;
        check("err_set_wins", 64'(err), 64'd1);
        tick();
        err_clr = 1'b0;
        check("err_clr2", 64'(err), 64'd0);

        // Reset during the second of four read beats
        request(1'b0, 3, 32'h10);
        tick();
        tick();
        check("rst_rd_beat0", mif.mem_rd_bits, 64'h33);
        tick();
        check("rst_rd_beat1", mif.mem_rd_bits, 64'h44);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(mif.mem_rd_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        tick();
        request(1'b0, 0, 32'h18);
        tick();
        tick();
        check("post_rst_valid", 64'(mif.mem_rd_valid), 64'd1);
        check("post_rst_data", mif.mem_rd_bits, 64'h44);
        tick();
        check("post_rst_done", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
